uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered 8N1 UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first onto the TX pin at a fixed baud divisor. It is the transmit-side counterpart of `uart_rx` and shares its `BAUD_MULT` convention. It sits between board top-level logic and an output pin such as `PIN_2`. Back-to-back queued bytes go out with no idle gap.

## Interface
- `BAUD_MULT`, 1666: clock cycles per bit. Must be ≥ 2. 16 MHz / 1666 ≈ 9600 baud.
- `FIFO_DEPTH`, 4: byte slots. Must be a power of two, ≥ 2.
- `i_uart_clk` in, 1: single clock; all logic on its rising edge.
- `i_rst_n` in, 1: asynchronous, active-low reset. Asserted low immediately resets all state; deassertion is synchronous to `i_uart_clk`.
- `i_tx_byte` in, 8: byte to send.
- `i_tx_valid` in, 1: `i_tx_byte` is valid this cycle.
- `o_tx_ready` out, 1: FIFO can accept a byte.
- `o_tx_data` out, 1: serial line. Idle high.
- `o_tx_active` out, 1: a frame is on the line (start through stop).
- `o_tx_done` out, 1: one-cycle pulse on the last cycle of each stop bit.
- `o_fifo_count` out, $clog2(FIFO_DEPTH+1): queued bytes, not counting the byte being shifted.

## Operation
- Push:
  - A byte is accepted when `i_tx_valid && o_tx_ready` at a rising edge.
  - `o_tx_ready = (o_fifo_count != FIFO_DEPTH)`. It is registered-state based only; there is no bypass.
  - A push while full is dropped silently, and the count is unchanged.
- FSM states:
  - IDLE: line = 1. Leaves IDLE when the FIFO is non-empty: pops the head into the shift register and goes to START.
  - START: line = 0 for BAUD_MULT cycles, then DATA.
  - DATA: line = shift[0]; shifts right every BAUD_MULT cycles. After 8 bits, goes to PARITY (if enabled) or STOP.
  - PARITY: line = even parity of the byte for BAUD_MULT cycles, then STOP.
  - STOP: line = 1 for BAUD_MULT cycles. At the end, `o_tx_done` pulses. If the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Baud counter:
  - Width $clog2(BAUD_MULT).
  - Counts 0..BAUD_MULT-1 and reloads to 0 on every state change.
- Bit counter: 3 bits, wraps 7→0 on the transition DATA→next.
- FIFO pointers: $clog2(FIFO_DEPTH) bits, natural wrap-around.
- Simultaneous push and pop:
  - Both occur and the count is unchanged.
  - When full, the push is still refused, because ready was low.
- Reset values:
  - `o_tx_data`=1, `o_tx_active`=0, `o_tx_done`=0, `o_tx_ready`=1, `o_fifo_count`=0.
  - FSM=IDLE; pointers and counters = 0.
- Reset mid-frame: the line returns to 1 immediately. Queued and in-flight bytes are discarded, and no `o_tx_done` pulse occurs.

## Timing
- `o_tx_data` is driven from a register; no combinational path from the inputs.
- Accept at edge N with the FSM idle and the FIFO empty:
  - Pop at edge N+1.
  - Start bit visible from N+1.
  - `o_tx_active` is high from N+1.
- Frame length:
  - 10·BAUD_MULT cycles.
  - 11·BAUD_MULT cycles with parity.
- Back-to-back frames: the next start bit begins the cycle after the `o_tx_done` pulse, with zero idle cycles.
- `o_fifo_count`:
  - Increments the cycle after a push.
  - Decrements the cycle after a pop.
- `o_tx_active` falls the cycle after the `o_tx_done` pulse if no next byte is queued.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state exists and an even parity bit is inserted after D7. Frame is 11 bits.
  - Undefined: the PARITY state and its logic are absent. Frame is 10 bits (8N1).

## Structure
- Shared package `uart_pkg`:
  - FSM state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, in a 3-bit typedef.
  - Frame bit-count constants.
  - Default `BAUD_MULT`.
  - `uart_rx` uses the same package.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with push/pop/count/full/empty. It has the same clock and reset, and `FIFO_DEPTH` is its parameter.
- FSM, baud counter, and shift register live in `uart_tx_buffered`.

## Test plan
All scenarios use BAUD_MULT=3 and FIFO_DEPTH=4.
- Single byte 0x41 pushed from idle:
  - Line is 0 for 3 cycles.
  - Then bits 1,0,0,0,0,0,1,0 at 3 cycles each.
  - Then 1 for 3 cycles.
  - `o_tx_done` pulses once, 30 cycles after the start bit begins.
- Push 0x55 and 0xAA on consecutive cycles: two frames with no idle gap, and `o_tx_done` pulses exactly 30 cycles apart.
- Push 6 bytes 0x01..0x06 at one per cycle while idle:
  - 0x01 is popped immediately, so 0x02..0x05 fill the FIFO.
  - `o_tx_ready` goes low when the count reaches 4.
  - 0x06 is dropped.
  - The line carries 0x01..0x05 only.
- With the FIFO full, a push during the stop-bit pop cycle is refused; the count goes 4→3.
- Assert `i_rst_n` low during D3 of a 0x00 frame:
  - `o_tx_data`=1 in the same cycle.
  - Count 0, ready 1, no done pulse.
  - After release, the next push sends a clean frame.
- With `UART_TX_PARITY_EN` defined, push 0x07: the parity bit is 1, the frame is 33 cycles, and the stop bit follows.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame sizes and default baud divisor.
// Used by both the transmit and receive sides.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_FRAME_BITS_8N1 = 10;
  localparam int UART_FRAME_BITS_PAR = 11;

  // 16 MHz / 1666 ~= 9600 baud
  localparam int UART_BAUD_MULT_DEF  = 1666;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Pushes while full and pops while
// empty are ignored; pointers wrap naturally (FIFO_DEPTH is a power of two).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              push_i,
  input  logic [UART_DATA_BITS-1:0]         data_i,
  input  logic                              pop_i,
  output logic [UART_DATA_BITS-1:0]         data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              full_o,
  output logic                              empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]             wr_q, rd_q;
  logic [CW-1:0]             cnt_q;
  logic                      do_push, do_pop;

  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter, LSB first, back-to-back frames with no idle gap.
// Define UART_TX_PARITY_EN to insert an even parity bit after D7 (8E1).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int BAUD_MULT  = UART_BAUD_MULT_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              i_uart_clk,
  input  logic                              i_rst_n,
  input  logic [UART_DATA_BITS-1:0]         i_tx_byte,
  input  logic                              i_tx_valid,
  output logic                              o_tx_ready,
  output logic                              o_tx_data,
  output logic                              o_tx_active,
  output logic                              o_tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);

  localparam int              BW        = $clog2(BAUD_MULT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_MULT - 1);

  uart_state_t               state_q, state_d;
  logic [BW-1:0]             baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      baud_end;
  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_data;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_uart_clk),
    .rst_ni  (i_rst_n),
    .push_i  (i_tx_valid),
    .data_i  (i_tx_byte),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .count_o (o_fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign baud_end    = (baud_q == BAUD_LAST);
  assign o_tx_ready  = !fifo_full;
  assign o_tx_data   = tx_q;
  assign o_tx_active = (state_q != ST_IDLE);
  assign o_tx_done   = (state_q == ST_STOP) && baud_end;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_end ? '0 : baud_q + BW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_data;
`endif
        end
      end
      ST_START: if (baud_end) state_d = ST_DATA;
      ST_DATA: if (baud_end) begin
        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (baud_end) state_d = ST_STOP;
`endif
      ST_STOP: if (baud_end) begin
        // Chain straight into the next start bit when more bytes are queued.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_data;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase

    // Line value is registered from the next state so it lines up with it.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at BAUD_MULT=3, FIFO_DEPTH=4.
// Honours UART_TX_PARITY_EN when defined for the build.
module tb_uart_tx_buffered;

  localparam int BM = 3;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * BM;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ready, line, active, done;
  logic [2:0] count;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  logic [7:0] rx_q[$];

  uart_tx_buffered #(.BAUD_MULT(BM), .FIFO_DEPTH(4)) dut (
    .i_uart_clk   (clk),
    .i_rst_n      (rst_n),
    .i_tx_byte    (tx_byte),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (ready),
    .o_tx_data    (line),
    .o_tx_active  (active),
    .o_tx_done    (done),
    .o_fifo_count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line waveform of one frame, one bit per clock cycle, start bit at bit 0.
  function automatic logic [63:0] frame_exp(input logic [7:0] b);
    logic [10:0] f;
    logic [63:0] r;
    r = '0;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {2'b01, b, 1'b0};
`endif
    for (int i = 0; i < FB; i++)
      for (int j = 0; j < BM; j++)
        r[i*BM + j] = f[i];
    return r;
  endfunction

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic capture(output logic [63:0] v, output logic [63:0] d);
    v = '0;
    d = '0;
    for (int i = 0; i < FL; i++) begin
      v[i] = line;
      d[i] = done;
      @(negedge clk);
    end
  endtask

  // Independent receiver: samples the middle cycle of each bit.
  initial begin : rx_mon
    logic        busy;
    logic        prev;
    int          ph;
    logic [10:0] sh;
    busy = 1'b0;
    prev = 1'b1;
    ph   = 0;
    sh   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        prev = 1'b1;
      end else begin
        if (done) n_done++;
        if (!busy) begin
          if (prev && !line) begin
            busy = 1'b1;
            ph   = 0;
          end
        end else begin
          ph++;
        end
        if (busy && (ph % BM) == 1) begin
          sh[ph/BM] = line;
          if (ph/BM == FB-1) begin
            busy = 1'b0;
            rx_q.push_back(sh[8:1]);
          end
        end
        prev = line;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] v, d;
    int found, dn;

    repeat (3) @(negedge clk);
    chk("rst_line",   line,   1);
    chk("rst_active", active, 0);
    chk("rst_done",   done,   0);
    chk("rst_ready",  ready,  1);
    chk("rst_count",  count,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0x41 from idle
    push(8'h41);
    chk("s1_count_push", count,  1);
    chk("s1_line_idle",  line,   1);
    chk("s1_active_pre", active, 0);
    @(negedge clk);
    chk("s1_active", active, 1);
    capture(v, d);
    chk("s1_frame", v, frame_exp(8'h41));
`ifndef UART_TX_PARITY_EN
    chk("s1_frame_const", v, 64'h38E00038);
`endif
    chk("s1_done_pos",   d,      64'd1 << (FL-1));
    chk("s1_active_end", active, 0);
    chk("s1_line_end",   line,   1);

    // Two consecutive pushes, frames back to back
    tx_valid = 1'b1;
    tx_byte  = 8'h55;
    @(negedge clk);
    tx_byte  = 8'hAA;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("s2_active", active, 1);
    chk("s2_count",  count,  1);
    capture(v, d);
    chk("s2_frame0", v, frame_exp(8'h55));
    chk("s2_done0",  d, 64'd1 << (FL-1));
    capture(v, d);
    chk("s2_frame1", v, frame_exp(8'hAA));
    chk("s2_done1",  d, 64'd1 << (FL-1));
    chk("s2_active_end", active, 0);

    // Six pushes at one per cycle; fifth fills the FIFO, sixth is dropped
    rx_q.delete();
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_byte = 8'(i + 1);
      chk("s3_ready", ready, (i < 5) ? 1 : 0);
      chk("s3_count", count, (i == 0) ? 0 : (i == 1) ? 1 : i - 1);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("s3_count_full", count, 4);
    chk("s3_ready_full", ready, 0);

    found = 0;
    for (int i = 0; i < FL + 5 && found == 0; i++) begin
      if (done) found = 1;
      else @(negedge clk);
    end
    chk("s4_done_seen", found, 1);
    tx_valid = 1'b1;
    tx_byte  = 8'h77;
    chk("s4_ready_stop", ready, 0);
    chk("s4_count_stop", count, 4);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("s4_count_pop", count, 3);
    chk("s4_ready_pop", ready, 1);

    found = 0;
    for (int i = 0; i < 6*FL && found == 0; i++) begin
      if (!active) found = 1;
      else @(negedge clk);
    end
    chk("s3_drain", found, 1);
    chk("s3_rx_n", rx_q.size(), 5);
    for (int i = 0; i < rx_q.size() && i < 5; i++)
      chk("s3_rx_byte", rx_q[i], 64'(i + 1));

    // Reset during D3 of a 0x00 frame
    dn = n_done;
    push(8'h00);
    repeat (14) @(negedge clk);
    chk("s5_d3_line",   line,   0);
    chk("s5_d3_active", active, 1);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_line",   line,   1);
    chk("s5_rst_count",  count,  0);
    chk("s5_rst_ready",  ready,  1);
    chk("s5_rst_active", active, 0);
    chk("s5_rst_done",   done,   0);
    @(negedge clk);
    chk("s5_rst_done2",  done,   0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s5_no_done", n_done - dn, 0);
    rx_q.delete();
    push(8'h3C);
    @(negedge clk);
    capture(v, d);
    chk("s5_frame", v, frame_exp(8'h3C));
    chk("s5_done",  d, 64'd1 << (FL-1));
    chk("s5_rx_n",  rx_q.size(), 1);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    push(8'h07);
    @(negedge clk);
    capture(v, d);
    chk("p_frame",  v, frame_exp(8'h07));
    chk("p_bit",    v[9*BM +: BM], 3'b111);
    chk("p_stop",   v[10*BM +: BM], 3'b111);
    chk("p_done",   d, 64'd1 << 32);
    chk("p_active", active, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
